branch_resolver: RTL
====================

Name: branch_resolver

Overview:
- Consumes the EX-stage ALU compare result (branch-taken flag) and the branch operands latched in ID/EX.
- Computes the branch target and drives a registered PC redirect into IF.
- Sequences flush of the IF/ID and ID/EX pipeline registers for a fixed number of bubble cycles.
- Sits between the ALU output and the fetch/hazard logic.

Parameters:
- ADDR_W, 32: PC/target width.
- FLUSH_CYCLES, 2: cycles flush_ifid/flush_idex stay asserted per taken branch. Must be >=1; elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- ex_valid  in  1  EX stage holds a real instruction
- ex_is_branch  in  1  EX instruction is a conditional branch
- alu_branch  in  1  ALU equality flag; meaningful only when ex_valid && ex_is_branch
- ex_pc  in  ADDR_W  PC+4 of the branch
- ex_offset  in  ADDR_W  sign-extended word offset
- stall  in  1  hazard-unit stall; pipeline registers and PC hold
- pc_redirect  out  1  IF loads pc_target this cycle
- pc_target  out  ADDR_W  registered branch target
- flush_ifid  out  1  clear IF/ID to bubble
- flush_idex  out  1  clear ID/EX to bubble
- busy  out  1  redirect/flush sequence in progress

Behaviour:
- Reset (rst_n low, async): state IDLE, pc_target=0, pc_redirect=0, flush_ifid=0, flush_idex=0, busy=0, flush counter=0. Reset mid-sequence aborts it immediately; no redirect after release.
- Target: ex_pc + (ex_offset << 2), truncated to ADDR_W. Wraps modulo 2^ADDR_W; no overflow flag.
- take = ex_valid && ex_is_branch && alu_branch. alu_branch is ignored whenever the qualifier is false, including X or stale values.
- All outputs are registered.
- IDLE:
  - take && !stall: latch target; next state REDIRECT.
  - take && stall: no action; the branch re-presents next cycle.
  - Not-taken or non-branch: stay IDLE.
- REDIRECT:
  - pc_redirect=1, flush_ifid=1, flush_idex=1, busy=1.
  - If stall: hold all outputs and state.
  - Else: FLUSH_CYCLES==1 goes to IDLE; otherwise load counter with FLUSH_CYCLES-1 and go to FLUSH.
- FLUSH:
  - pc_redirect=0, flush_ifid=1, flush_idex=1, busy=1.
  - Counter decrements only when !stall; at 0, go to IDLE.
- While busy, EX instructions are wrong-path: take is ignored, and pc_target is not reloaded.
- Latency: a taken branch resolved in EX at cycle N gives pc_redirect high in cycle N+1. Flush is high for FLUSH_CYCLES unstalled cycles starting at N+1. busy falls at N+1+FLUSH_CYCLES with no stalls.
- Back-to-back: a taken branch arriving in the same cycle the FSM returns to IDLE (busy already 0) is accepted normally.

Optional Feature:
- Macro: BRANCH_RESOLVER_STATS_EN.
- Defined: adds outputs stat_resolved (32) and stat_taken (32).
  - stat_resolved increments on each accepted ex_valid && ex_is_branch in IDLE with !stall.
  - stat_taken increments when such a branch is taken.
  - Both wrap at 2^32; reset to 0.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package branch_pkg:
  - state enum {IDLE, REDIRECT, FLUSH}
  - WORD_SHIFT=2
  - default ADDR_W
- Sub-module branch_stats (the two counters) instantiated only under BRANCH_RESOLVER_STATS_EN.
- Target adder and FSM stay inline.

Test Plan:
- Reset: rst_n low mid-FLUSH -> all outputs 0 asynchronously; after release, no redirect without a new take.
- Taken branch: ex_pc=0x100, ex_offset=0x3, alu_branch=1, cycle N -> cycle N+1 pc_redirect=1, pc_target=0x10C; flush high in N+1 and N+2; busy=0 at N+3 (FLUSH_CYCLES=2).
- Backward/wrap: ex_pc=0x8, ex_offset=0xFFFFFFFC -> pc_target=0xFFFFFFF8; ex_pc=0xFFFFFFFC, offset=0x1 -> pc_target=0x0.
- Not-taken and unqualified: alu_branch=1 with ex_is_branch=0, and alu_branch=0 with ex_is_branch=1 -> no redirect, no flush, busy=0.
- Stall: take with stall=1 for 3 cycles -> nothing. Stall raised during REDIRECT -> pc_redirect held until stall drops, then flush sequence completes with correct length.
- Wrong-path: second taken branch during busy -> ignored, pc_target unchanged. With STATS_EN: stat_resolved=1, stat_taken=1.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolver.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam int WORD_SHIFT     = 2;
  localparam int DEFAULT_ADDR_W = 32;

endpackage : branch_pkg

// File: rtl/branch_stats.sv
// Resolved/taken branch event counters; both wrap at 2^32.
module branch_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        resolve_i,
  input  logic        taken_i,
  output logic [31:0] stat_resolved_o,
  output logic [31:0] stat_taken_o
);

  logic [31:0] resolved_q, resolved_d;
  logic [31:0] taken_q, taken_d;

  // Next-count selection
  always_comb begin
    resolved_d = resolved_q;
    taken_d    = taken_q;
    if (resolve_i) begin
      resolved_d = resolved_q + 32'd1;
      if (taken_i) begin
        taken_d = taken_q + 32'd1;
      end else begin
        taken_d = taken_q;
      end
    end else begin
      resolved_d = resolved_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolved_q <= 32'd0;
      taken_q    <= 32'd0;
    end else begin
      resolved_q <= resolved_d;
      taken_q    <= taken_d;
    end
  end

  assign stat_resolved_o = resolved_q;
  assign stat_taken_o    = taken_q;

endmodule : branch_stats

// File: rtl/branch_resolver.sv
// EX-stage branch resolution: registered PC redirect plus IF/ID, ID/EX flush sequencing.
// Optional counters enabled by defining BRANCH_RESOLVER_STATS_EN.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              alu_branch,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_offset,
  input  logic              stall,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_ifid,
  output logic              flush_idex,
`ifdef BRANCH_RESOLVER_STATS_EN
  output logic              busy,
  output logic [31:0]       stat_resolved,
  output logic [31:0]       stat_taken
`else
  output logic              busy
`endif
);

  if (FLUSH_CYCLES < 1) begin : g_bad_cfg
    $error("branch_resolver: FLUSH_CYCLES must be >= 1");
  end

  localparam int              CNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              redirect_q, redirect_d;
  logic              flush_q, flush_d;

  logic              take_s;
  logic              resolve_s;
  logic [ADDR_W-1:0] target_s;

  // Qualifier gates alu_branch so a stale/unknown flag never leaks into take
  assign take_s    = ex_valid && ex_is_branch && alu_branch;
  assign resolve_s = (state_q == IDLE) && ex_valid && ex_is_branch && !stall;
  assign target_s  = ex_pc + (ex_offset << WORD_SHIFT);

  // Next-state, counter and target selection
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        if (take_s && !stall) begin
          target_d = target_s;
          state_d  = REDIRECT;
        end else begin
          state_d  = IDLE;
        end
      end
      REDIRECT: begin
        if (stall) begin
          state_d = REDIRECT;
        end else if (FLUSH_CYCLES == 1) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (stall) begin
          state_d = FLUSH;
        end else if (cnt_q > CNT_ONE) begin
          cnt_d   = cnt_q - CNT_ONE;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    redirect_d = (state_d == REDIRECT);
    flush_d    = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      target_q   <= '0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
    end
  end

  assign pc_redirect = redirect_q;
  assign pc_target   = target_q;
  assign flush_ifid  = flush_q;
  assign flush_idex  = flush_q;
  assign busy        = flush_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  branch_stats u_stats (
    .clk             (clk),
    .rst_n           (rst_n),
    .resolve_i       (resolve_s),
    .taken_i         (alu_branch),
    .stat_resolved_o (stat_resolved),
    .stat_taken_o    (stat_taken)
  );
`else
  logic unused_s;
  assign unused_s = resolve_s;
`endif

endmodule : branch_resolver
